knapsack_enumerator: RTL and testbench

- Sequential candidate generator that sits directly upstream of the combinational knapsack verifier.
- On a start pulse it walks every subset of N_ITEMS items, one per clock, and drives each subset onto the verifier's item-select inputs.
- It samples the verifier's valid flag for each subset and reports three results: whether any subset passed, the first passing subset, and the number of passing subsets.
- It gives the verifier a brute-force driver for the decision form of the problem.

---
 rtl/knapsack_pkg.sv | 37 +++
 rtl/knapsack_enumerator.sv | 87 ++++++++
 tb/tb_knapsack_enumerator.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/knapsack_pkg.sv
// Shared definitions for the knapsack enumerator and its verifier: FSM states, default width, and the A-E item set.
// The enumerator's optional early-exit mode is selected by KNAP_STOP_ON_FIRST_EN.
package knapsack_pkg;

    localparam int N_ITEMS_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Item k occupies byte k: A is byte 0, E is byte 4.
    localparam logic [4:0][7:0] ITEM_WEIGHT = {8'd4, 8'd1, 8'd1, 8'd2, 8'd12};
    localparam logic [4:0][7:0] ITEM_VALUE  = {8'd10, 8'd2, 8'd1, 8'd2, 8'd4};
    localparam logic [7:0]      CAPACITY    = 8'd15;
    localparam logic [7:0]      TARGET      = 8'd15;

    // Reference for the decision question: fits the capacity and reaches the target value.
    function automatic logic knap_valid(input logic [4:0] sel);
        logic [7:0] weight_sum;
        logic [7:0] value_sum;
        weight_sum = 8'd0;
        value_sum  = 8'd0;
        for (int i = 0; i < 5; i++) begin
            if (sel[i]) begin
                weight_sum = weight_sum + ITEM_WEIGHT[i];
                value_sum  = value_sum + ITEM_VALUE[i];
            end else begin
                weight_sum = weight_sum;
                value_sum  = value_sum;
            end
        end
        return (weight_sum <= CAPACITY) && (value_sum >= TARGET);
    endfunction

endpackage

// File: rtl/knapsack_enumerator.sv
// Brute-force subset walker that drives the knapsack verifier and reports found / first pass / pass count.
// Define KNAP_STOP_ON_FIRST_EN to end the scan at the first passing subset.
module knapsack_enumerator
    import knapsack_pkg::*;
#(
    parameter int N_ITEMS = N_ITEMS_DEF,
    parameter int CNT_W   = N_ITEMS + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               chk_valid_i,
    output logic [N_ITEMS-1:0] sel_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               found_o,
    output logic [N_ITEMS-1:0] first_sel_o,
    output logic [CNT_W-1:0]   pass_cnt_o
);

    localparam logic [N_ITEMS-1:0] SEL_LAST = {N_ITEMS{1'b1}};
    localparam logic [N_ITEMS-1:0] SEL_ONE  = N_ITEMS'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    state_t state_r;
    logic   scan_end_s;

`ifdef KNAP_STOP_ON_FIRST_EN
    assign scan_end_s = chk_valid_i || (sel_o == SEL_LAST);
`else
    assign scan_end_s = (sel_o == SEL_LAST);
`endif

    // Scan FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            sel_o       <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            found_o     <= 1'b0;
            first_sel_o <= '0;
            pass_cnt_o  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        sel_o       <= '0;
                        found_o     <= 1'b0;
                        first_sel_o <= '0;
                        pass_cnt_o  <= '0;
                        busy_o      <= 1'b1;
                        state_r     <= SCAN;
                    end
                end
                SCAN: begin
                    if (chk_valid_i) begin
                        pass_cnt_o <= pass_cnt_o + CNT_ONE;
                        if (!found_o) begin
                            first_sel_o <= sel_o;
                            found_o     <= 1'b1;
                        end
                    end
                    // sel_o is left on the last candidate so it stays visible after the scan.
                    if (scan_end_s) begin
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        sel_o <= sel_o + SEL_ONE;
                    end
                end
                DONE: begin
                    done_o  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knapsack_enumerator.sv
// Directed bench for knapsack_enumerator with a behavioural A-E verifier and constant-valid stubs.
// Expectations follow KNAP_STOP_ON_FIRST_EN when it is defined for the build.
module tb_knapsack_enumerator;
    import knapsack_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       chk_valid_i;
    logic [4:0] sel_o;
    logic       busy_o;
    logic       done_o;
    logic       found_o;
    logic [4:0] first_sel_o;
    logic [5:0] pass_cnt_o;

    int vectors = 0;
    int miscompares = 0;
    int mode = 0;  // 0 = A-E verifier, 1 = valid tied high, 2 = valid tied low

    knapsack_enumerator dut (
        .clk(clk), .rst(rst), .start_i(start_i), .chk_valid_i(chk_valid_i),
        .sel_o(sel_o), .busy_o(busy_o), .done_o(done_o), .found_o(found_o),
        .first_sel_o(first_sel_o), .pass_cnt_o(pass_cnt_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        chk_valid_i = 1'b0;
        case (mode)
            0: chk_valid_i = knap_valid(sel_o);
            1: chk_valid_i = 1'b1;
            default: chk_valid_i = 1'b0;
        endcase
    end

    // Pulse start and count cycles (start cycle = 0) until done_o is seen, bounded at 100.
    task automatic run_scan(output int cycles);
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cycles = 1;
        while (!done_o && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic wait_sel(input logic [4:0] target);
        int guard = 0;
        while (sel_o !== target && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        vectors++;
        if (sel_o !== target) begin
            miscompares++;
            $display("FAIL wait_sel: sel_o=%0d never reached %0d", sel_o, target);
        end
    endtask

    task automatic check_results(input string name, input int cycles, input int exp_cycles,
                                 input logic exp_found, input logic [4:0] exp_first,
                                 input logic [5:0] exp_cnt);
        vectors++;
        if (cycles !== exp_cycles) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d expected %0d", name, cycles, exp_cycles);
        end
        vectors++;
        if ({busy_o, found_o, first_sel_o, pass_cnt_o} !== {1'b0, exp_found, exp_first, exp_cnt}) begin
            miscompares++;
            $display("FAIL %s_results: busy=%b found=%b first=%b cnt=%0d expected busy=0 found=%b first=%b cnt=%0d",
                     name, busy_o, found_o, first_sel_o, pass_cnt_o, exp_found, exp_first, exp_cnt);
        end
        @(posedge clk); #1;
        vectors++;
        if ({done_o, found_o, first_sel_o, pass_cnt_o} !== {1'b0, exp_found, exp_first, exp_cnt}) begin
            miscompares++;
            $display("FAIL %s_hold: done=%b found=%b first=%b cnt=%0d expected done=0 found=%b first=%b cnt=%0d",
                     name, done_o, found_o, first_sel_o, pass_cnt_o, exp_found, exp_first, exp_cnt);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({sel_o, busy_o, done_o, found_o, first_sel_o, pass_cnt_o} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset: outputs=%b expected all zero",
                     {sel_o, busy_o, done_o, found_o, first_sel_o, pass_cnt_o});
        end
        rst = 1'b0;
    endtask

    task automatic test_verifier;
        int cycles;
        mode = 0;
        run_scan(cycles);
`ifdef KNAP_STOP_ON_FIRST_EN
        check_results("verifier", cycles, 32, 1'b1, 5'b11110, 6'd1);
`else
        check_results("verifier", cycles, 33, 1'b1, 5'b11110, 6'd1);
`endif
    endtask

    task automatic test_all_pass;
        int cycles;
        mode = 1;
        run_scan(cycles);
`ifdef KNAP_STOP_ON_FIRST_EN
        check_results("all_pass", cycles, 2, 1'b1, 5'd0, 6'd1);
`else
        check_results("all_pass", cycles, 33, 1'b1, 5'd0, 6'd32);
`endif
    endtask

    task automatic test_none_pass;
        int cycles;
        mode = 2;
        run_scan(cycles);
        check_results("none_pass", cycles, 33, 1'b0, 5'd0, 6'd0);
    endtask

    task automatic test_reset_mid_scan;
        int cycles;
        int dones = 0;
        mode = 2;
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_sel(5'd10);
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_scan_busy: got %b expected 1", busy_o);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if ({sel_o, busy_o, done_o, found_o, first_sel_o, pass_cnt_o} !== 19'd0) begin
            miscompares++;
            $display("FAIL mid_scan_reset: outputs=%b expected all zero",
                     {sel_o, busy_o, done_o, found_o, first_sel_o, pass_cnt_o});
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (done_o) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL mid_scan_no_done: got %0d done pulses expected 0", dones);
        end
        mode = 0;
        run_scan(cycles);
`ifdef KNAP_STOP_ON_FIRST_EN
        check_results("restart", cycles, 32, 1'b1, 5'b11110, 6'd1);
`else
        check_results("restart", cycles, 33, 1'b1, 5'b11110, 6'd1);
`endif
    endtask

    task automatic test_start_ignored;
        int dones = 0;
        int done_at = 0;
        int cycles;
        mode = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cycles = 1;
        while (sel_o !== 5'd5 && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cycles++;
        repeat (60) begin
            if (done_o) begin
                dones++;
                done_at = cycles;
            end
            @(posedge clk); #1;
            cycles++;
        end
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL restart_ignored_dones: got %0d expected 1", dones);
        end
        vectors++;
`ifdef KNAP_STOP_ON_FIRST_EN
        if (done_at !== 32 || sel_o !== 5'd30) begin
            miscompares++;
            $display("FAIL restart_ignored_end: done_at=%0d sel=%0d expected 32 and 30", done_at, sel_o);
        end
`else
        if (done_at !== 33 || sel_o !== 5'd31) begin
            miscompares++;
            $display("FAIL restart_ignored_end: done_at=%0d sel=%0d expected 33 and 31", done_at, sel_o);
        end
`endif
    endtask

    task automatic test_start_with_rst;
        int dones = 0;
        @(negedge clk);
        rst = 1'b1;
        start_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start_i = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_o || busy_o) dones++;
        end
        vectors++;
        if (dones !== 0 || sel_o !== 5'd0) begin
            miscompares++;
            $display("FAIL start_with_rst: active cycles=%0d sel=%0d expected 0 and 0", dones, sel_o);
        end
    endtask

    initial begin
        test_reset();
        test_verifier();
        test_all_pass();
        test_none_pass();
        test_reset_mid_scan();
        test_start_ignored();
        test_start_with_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
